// File: rtl/extensor_unit.sv
`default_nettype none
// ============================================================================
// Module      : extensor_unit
// Description : MIPS immediate extender. Widens a 16-bit immediate to a 32-bit
//               operand (sign/zero/LUI/branch/byte modes), combinational result
//               plus a registered copy with a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module extensor_unit #(
    parameter int                IN_W    = 16,
    parameter int                OUT_W   = 32,
    parameter logic [OUT_W-1:0]  RST_VAL = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in,
    input  logic [2:0]       mode,
    input  logic             en,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic             out_valid,
    output logic             neg
);

    localparam logic [2:0] c_SEXT16 = 3'd0;
    localparam logic [2:0] c_ZEXT16 = 3'd1;
    localparam logic [2:0] c_LUI    = 3'd2;
    localparam logic [2:0] c_BRANCH = 3'd3;
    localparam logic [2:0] c_SEXT8  = 3'd4;
    localparam logic [2:0] c_ZEXT8  = 3'd5;

    logic [OUT_W-1:0] w_ext;
    logic             w_neg;
    logic [OUT_W-1:0] r_out_q;
    logic             r_out_valid;

    // Reserved and unknown mode values fall to the default branch (SEXT16)
    // so nothing stale is ever held.
    always_comb begin
        w_ext = {{16{in[15]}}, in};
        w_neg = in[15];
        case (mode)
            c_SEXT16: begin
                w_ext = {{16{in[15]}}, in};
                w_neg = in[15];
            end
            c_ZEXT16: begin
                w_ext = {16'h0000, in};
                w_neg = 1'b0;
            end
            c_LUI: begin
                w_ext = {in, 16'h0000};
                w_neg = in[15];
            end
            c_BRANCH: begin
                w_ext = {{14{in[15]}}, in, 2'b00};
                w_neg = in[15];
            end
            c_SEXT8: begin
                w_ext = {{24{in[7]}}, in[7:0]};
                w_neg = in[7];
            end
            c_ZEXT8: begin
                w_ext = {24'h000000, in[7:0]};
                w_neg = 1'b0;
            end
            default: begin
                w_ext = {{16{in[15]}}, in};
                w_neg = in[15];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q     <= RST_VAL;
            r_out_valid <= 1'b0;
        end else if (en) begin
            r_out_q     <= w_ext;
            r_out_valid <= 1'b1;
        end
    end

    assign out       = w_ext;
    assign neg       = w_neg;
    assign out_q     = r_out_q;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_extensor_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_extensor_unit
// Description : Directed scoreboard bench for extensor_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_extensor_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic [2:0]  mode;
    logic        en;
    logic [31:0] out;
    logic [31:0] out_q;
    logic        out_valid;
    logic        neg;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_out_q[$];
    logic        exp_neg_q[$];
    logic [32:0] exp_reg_q[$];

    extensor_unit #(
        .IN_W   (16),
        .OUT_W  (32),
        .RST_VAL(32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .mode     (mode),
        .en       (en),
        .out      (out),
        .out_q    (out_q),
        .out_valid(out_valid),
        .neg      (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive a combinational vector, queue its expectation, then pop and compare.
    task automatic comb_step(input string tag, input logic [2:0] m, input logic [15:0] v,
                             input logic [31:0] e_out, input logic e_neg);
        logic [31:0] eo;
        logic        en_exp;
        mode = m;
        in   = v;
        exp_out_q.push_back(e_out);
        exp_neg_q.push_back(e_neg);
        #1;
        if (exp_out_q.size() == 0 || exp_neg_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            eo     = exp_out_q.pop_front();
            en_exp = exp_neg_q.pop_front();
            check({tag, "_out"}, out, eo);
            check({tag, "_neg"}, {31'd0, neg}, {31'd0, en_exp});
        end
    endtask

    task automatic reg_check(input string tag);
        logic [32:0] e;
        if (exp_reg_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_reg_q.pop_front();
            check({tag, "_out_q"}, out_q, e[31:0]);
            check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, e[32]});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 3'd0;
        in    = 16'h0000;
        #3;

        exp_reg_q.push_back({1'b0, 32'h0000_0000});
        reg_check("reset");

        // Combinational path, held in reset to show independence from it.
        comb_step("sext_abea",   3'd0, 16'hABEA, 32'hFFFF_ABEA, 1'b1);
        comb_step("sext_zero",   3'd0, 16'h0000, 32'h0000_0000, 1'b0);
        comb_step("sext_7fff",   3'd0, 16'h7FFF, 32'h0000_7FFF, 1'b0);
        comb_step("sext_8000",   3'd0, 16'h8000, 32'hFFFF_8000, 1'b1);
        comb_step("zext_abea",   3'd1, 16'hABEA, 32'h0000_ABEA, 1'b0);
        comb_step("zext_ffff",   3'd1, 16'hFFFF, 32'h0000_FFFF, 1'b0);
        comb_step("lui_abea",    3'd2, 16'hABEA, 32'hABEA_0000, 1'b1);
        comb_step("br_abea",     3'd3, 16'hABEA, 32'hFFFE_AFA8, 1'b1);
        comb_step("br_8000",     3'd3, 16'h8000, 32'hFFFE_0000, 1'b1);
        comb_step("br_1234",     3'd3, 16'h1234, 32'h0000_48D0, 1'b0);
        comb_step("sext8_abea",  3'd4, 16'hABEA, 32'hFFFF_FFEA, 1'b1);
        comb_step("sext8_807f",  3'd4, 16'h807F, 32'h0000_007F, 1'b0);
        comb_step("zext8_abea",  3'd5, 16'hABEA, 32'h0000_00EA, 1'b0);
        comb_step("rsv6_abea",   3'd6, 16'hABEA, 32'hFFFF_ABEA, 1'b1);
        comb_step("rsv7_abea",   3'd7, 16'hABEA, 32'hFFFF_ABEA, 1'b1);
        comb_step("lui_7fff",    3'd2, 16'h7FFF, 32'h7FFF_0000, 1'b0);

        // Reset holds the register clear across an edge even with en high.
        en = 1'b1;
        @(posedge clk); #1;
        exp_reg_q.push_back({1'b0, 32'h0000_0000});
        reg_check("reset_en_hold");

        // Release between edges and capture 0x1234.
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 3'd0;
        in    = 16'h1234;
        en    = 1'b1;
        exp_reg_q.push_back({1'b1, 32'h0000_1234});
        @(posedge clk); #1;
        reg_check("capture_1234");

        // en low: register holds while out tracks the new input.
        @(negedge clk);
        en = 1'b0;
        comb_step("hold_out", 3'd0, 16'hFFFF, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        exp_reg_q.push_back({1'b1, 32'h0000_1234});
        reg_check("hold_1234");
        @(posedge clk); #1;
        exp_reg_q.push_back({1'b1, 32'h0000_1234});
        reg_check("hold_1234_b");

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        exp_reg_q.push_back({1'b0, 32'h0000_0000});
        reg_check("async_rst");
        comb_step("out_in_rst", 3'd0, 16'hABEA, 32'hFFFF_ABEA, 1'b1);

        // Capture in a non-default mode after release.
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 3'd2;
        in    = 16'hABEA;
        en    = 1'b1;
        exp_reg_q.push_back({1'b1, 32'hABEA_0000});
        @(posedge clk); #1;
        reg_check("capture_lui");

        @(negedge clk);
        mode = 3'd5;
        in   = 16'h00C3;
        exp_reg_q.push_back({1'b1, 32'h0000_00C3});
        @(posedge clk); #1;
        reg_check("capture_zext8");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/extensor_unit.md
Name: extensor_unit

Overview:
- Immediate extender for the MIPS datapath: widens a 16-bit instruction immediate to a 32-bit operand.
- Default mode is sign extension. Mode select adds zero-extend, LUI, branch-offset and byte-extend variants.
- Provides a combinational result `out` for the single-cycle datapath, plus a registered copy `out_q` for pipelined use.
- Sits between the instruction decode field imm[15:0] and the ALU-B / branch-adder muxes.

Parameters:
- IN_W, 16, input immediate width (fixed; other values not supported).
- OUT_W, 32, output word width (fixed; other values not supported).
- RST_VAL, 32'h0000_0000, value loaded into out_q on reset.

Ports:
- clk  input  1  system clock, rising edge active.
- rst_n  input  1  asynchronous active-low reset; affects registered outputs only.
- in  input  16  immediate field.
- mode  input  3  extension mode select (encoding below); 0 = sign extend.
- en  input  1  load enable for the output register.
- out  output  32  combinational extended result.
- out_q  output  32  registered extended result.
- out_valid  output  1  high when out_q holds a captured value.
- neg  output  1  combinational sign of the selected source field.

Behaviour:
- `out` is purely combinational.
  - No clock or reset dependency.
  - Settles within the same delta as changes on `in` or `mode`.
- Mode encoding:
  - 3'd0 SEXT16: out = {{16{in[15]}}, in}.
  - 3'd1 ZEXT16: out = {16'h0000, in}.
  - 3'd2 LUI: out = {in, 16'h0000}.
  - 3'd3 BRANCH: out = {{14{in[15]}}, in, 2'b00}, i.e. the sign-extended value shifted left 2.
  - 3'd4 SEXT8: out = {{24{in[7]}}, in[7:0]}.
  - 3'd5 ZEXT8: out = {24'h000000, in[7:0]}.
  - 3'd6, 3'd7: reserved; behave exactly as SEXT16.
- neg:
  - in[7] in SEXT8 mode.
  - 0 in ZEXT16 and ZEXT8 modes.
  - in[15] in all other modes.
- Registered path:
  - On rst_n low, asynchronously and immediately: out_q = RST_VAL, out_valid = 0.
  - On a rising clk with rst_n high and en = 1: out_q <= out, out_valid <= 1. Latency is 1 cycle.
  - On a rising clk with rst_n high and en = 0: out_q and out_valid hold.
- Reset asserted mid-operation clears the register regardless of en. `out` keeps tracking `in` during reset.
- Reset deassertion is synchronised by the integrator. The first capture occurs on the first rising edge with rst_n high and en = 1.
- Boundaries:
  - in = 16'h7FFF, SEXT16 -> 32'h00007FFF.
  - in = 16'h8000, SEXT16 -> 32'hFFFF8000.
  - in = 16'hFFFF, ZEXT16 -> 32'h0000FFFF.
  - BRANCH discards the top 2 extension bits: in = 16'h8000 -> 32'hFFFE0000.
- No X propagation: an X on `mode` must not hold stale data. Use a default case branch that selects SEXT16.

Test Plan:
- mode=0, in=16'b1010101111101010 (16'hABEA) -> out=32'hFFFFABEA, neg=1. Also in=0 -> out=0.
- mode=0, in=16'h7FFF then 16'h8000 -> out=32'h00007FFF, then 32'hFFFF8000.
- in=16'hABEA under each mode:
  - mode=1 -> out=32'h0000ABEA.
  - mode=2 -> out=32'hABEA0000.
  - mode=3 -> out=32'hFFFEAFA8.
  - mode=4 -> out=32'hFFFFFFEA.
  - mode=5 -> out=32'h000000EA.
  - mode=7 -> out=32'hFFFFABEA.
- Registered path, mode=0:
  - rst_n=0 -> out_q=0, out_valid=0.
  - Release reset, en=1, in=16'h1234 -> after one rising edge out_q=32'h00001234, out_valid=1.
  - en=0, in=16'hFFFF -> out_q holds 32'h00001234 while out=32'hFFFFFFFF.
- Asynchronous reset mid-stream: drop rst_n between clock edges while out_q=32'h00001234 -> out_q=0 and out_valid=0 immediately, with no clock edge.
